uart_mmio: RTL and testbench

- CPU-side, memory-mapped responder for the existing UART core.
- Sits between the CPU data-memory bus and the UART's tx_data/tx_enable/tx_status and rx_data/rx_status/rx_enable interface.
- Buffers outgoing bytes in a small TX FIFO and paces them into the UART using a handshake state machine.
- Captures received bytes into a holding register, exposes status and control registers, and raises an interrupt.

---
 rtl/uart_mmio_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 55 +++++
 rtl/uart_mmio.sv | 188 ++++++++++++++++++
 tb/tb_uart_mmio.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART memory-mapped responder: register offsets,
// CSR bit positions and the transmit handshake state encoding.
package uart_mmio_pkg;

    localparam logic [31:0] TXD_OFS = 32'd0;
    localparam logic [31:0] RXD_OFS = 32'd4;
    localparam logic [31:0] CSR_OFS = 32'd8;

    localparam int CSR_TX_FULL    = 0;
    localparam int CSR_TX_IDLE    = 1;
    localparam int CSR_RX_VALID   = 2;
    localparam int CSR_RX_OVERRUN = 3;
    localparam int CSR_TX_DROP    = 4;
    localparam int CSR_RX_IRQ_EN  = 5;
    localparam int CSR_TX_IRQ_EN  = 6;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } txState_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO holding outgoing UART bytes; a push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [AW:0]   count_q;
    logic          doPush;
    logic          doPop;

    assign full   = (count_q == (AW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);
    assign dout   = mem_q[rdPtr_q];
    assign count  = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= din;
                wrPtr_q        <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio.sv
// CPU-side MMIO responder for the UART core: TXD/RXD/CSR registers, TX FIFO
// pacing and RX capture. Define UART_IRQ_EN to build the interrupt logic.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0018,
    parameter int          TX_DEPTH     = 4,
    parameter int          BUSY_TIMEOUT = 1023
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_enable,
    input  logic        uart_tx_status,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_status,
    output logic        uart_rx_enable,
    output logic        irq
);

    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam int FW = $clog2(TX_DEPTH) + 1;

    logic          hitTxd, hitRxd, hitCsr;
    logic          txPush, txPop, txFull, txEmpty, txIdle;
    logic [7:0]    txHead;
    logic [FW-1:0] unusedTxCount;
    logic          unusedWdata;
    txState_e      txState_q;
    logic [CW-1:0] busyCnt_q;
    logic [7:0]    txData_q;
    logic          txEnable_q;
    logic [1:0]    txStatusSync_q;
    logic [1:0]    rxStatusSync_q;
    logic          rxStatusPrev_q;
    logic          rxEvent, rxRead, csrWrite;
    logic [7:0]    rxByte_q;
    logic          rxValid_q, rxOverrun_q, txDrop_q;
    logic          rxIrqEn, txIrqEn;
    logic [31:0]   csrValue;

    assign hitTxd   = (addr == BASE_ADDR + TXD_OFS);
    assign hitRxd   = (addr == BASE_ADDR + RXD_OFS);
    assign hitCsr   = (addr == BASE_ADDR + CSR_OFS);
    assign txPush   = mem_write & hitTxd;
    assign txPop    = (txState_q == TX_IDLE) & ~txEmpty;
    assign txIdle   = txEmpty & (txState_q == TX_IDLE);
    assign rxEvent  = rxStatusSync_q[1] & ~rxStatusPrev_q;
    assign rxRead   = mem_read & hitRxd;
    assign csrWrite = mem_write & hitCsr;

    assign uart_tx_data   = txData_q;
    assign uart_tx_enable = txEnable_q;
    assign uart_rx_enable = 1'b1;
    assign unusedWdata    = ^wdata;

    uart_tx_fifo #(.DEPTH(TX_DEPTH)) txFifo (
        .sysclk (sysclk),
        .reset  (reset),
        .push   (txPush),
        .pop    (txPop),
        .din    (wdata[7:0]),
        .dout   (txHead),
        .full   (txFull),
        .empty  (txEmpty),
        .count  (unusedTxCount)
    );

    // Handshake with the UART: pulse enable, wait for busy, wait for idle.
    // A UART that never reports busy gets the same byte re-pulsed after the timeout.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            txState_q      <= TX_IDLE;
            txData_q       <= '0;
            txEnable_q     <= 1'b0;
            busyCnt_q      <= '0;
            txStatusSync_q <= 2'b11;
        end else begin
            txStatusSync_q <= {txStatusSync_q[0], uart_tx_status};
            txEnable_q     <= 1'b0;
            case (txState_q)
                TX_IDLE: begin
                    if (txPop) begin
                        txData_q   <= txHead;
                        txEnable_q <= 1'b1;
                        txState_q  <= TX_START;
                    end
                end
                TX_START: begin
                    busyCnt_q <= '0;
                    txState_q <= TX_WAIT_BUSY;
                end
                TX_WAIT_BUSY: begin
                    if (!txStatusSync_q[1]) begin
                        txState_q <= TX_WAIT_DONE;
                    end else if (busyCnt_q == CW'(BUSY_TIMEOUT)) begin
                        txEnable_q <= 1'b1;
                        txState_q  <= TX_START;
                    end else begin
                        busyCnt_q <= busyCnt_q + 1'b1;
                    end
                end
                TX_WAIT_DONE: begin
                    if (txStatusSync_q[1]) begin
                        txState_q <= TX_IDLE;
                    end
                end
                default: txState_q <= TX_IDLE;
            endcase
        end
    end

    // A read that coincides with a new byte must not count as an overrun.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rxStatusSync_q <= '0;
            rxStatusPrev_q <= 1'b0;
            rxByte_q       <= '0;
            rxValid_q      <= 1'b0;
            rxOverrun_q    <= 1'b0;
            txDrop_q       <= 1'b0;
        end else begin
            rxStatusSync_q <= {rxStatusSync_q[0], uart_rx_status};
            rxStatusPrev_q <= rxStatusSync_q[1];
            if (rxEvent) begin
                rxByte_q  <= uart_rx_data;
                rxValid_q <= 1'b1;
            end else if (rxRead) begin
                rxValid_q <= 1'b0;
            end
            if (rxEvent && rxValid_q && !rxRead) begin
                rxOverrun_q <= 1'b1;
            end else if (csrWrite && wdata[CSR_RX_OVERRUN]) begin
                rxOverrun_q <= 1'b0;
            end
            if (txPush && txFull && !txPop) begin
                txDrop_q <= 1'b1;
            end else if (csrWrite && wdata[CSR_TX_DROP]) begin
                txDrop_q <= 1'b0;
            end
        end
    end

`ifdef UART_IRQ_EN
    logic rxIrqEn_q, txIrqEn_q, irq_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            rxIrqEn_q <= 1'b0;
            txIrqEn_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (csrWrite) begin
                rxIrqEn_q <= wdata[CSR_RX_IRQ_EN];
                txIrqEn_q <= wdata[CSR_TX_IRQ_EN];
            end
            irq_q <= (rxIrqEn_q & rxValid_q) | (txIrqEn_q & txIdle);
        end
    end

    assign rxIrqEn = rxIrqEn_q;
    assign txIrqEn = txIrqEn_q;
    assign irq     = irq_q;
`else
    assign rxIrqEn = 1'b0;
    assign txIrqEn = 1'b0;
    assign irq     = 1'b0;
`endif

    always_comb begin
        csrValue                 = '0;
        csrValue[CSR_TX_FULL]    = txFull;
        csrValue[CSR_TX_IDLE]    = txIdle;
        csrValue[CSR_RX_VALID]   = rxValid_q;
        csrValue[CSR_RX_OVERRUN] = rxOverrun_q;
        csrValue[CSR_TX_DROP]    = txDrop_q;
        csrValue[CSR_RX_IRQ_EN]  = rxIrqEn;
        csrValue[CSR_TX_IRQ_EN]  = txIrqEn;
    end

    assign rdata = hitRxd ? {24'h0, rxByte_q} : (hitCsr ? csrValue : 32'h0);

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: expected TX bytes and read data are queued by
// the stimulus and compared by a separate monitor. Honours UART_IRQ_EN.
module tb_uart_mmio;
    import uart_mmio_pkg::*;

    localparam logic [31:0] BASE         = 32'h4000_0018;
    localparam logic [31:0] TXD          = BASE;
    localparam logic [31:0] RXD          = BASE + 32'd4;
    localparam logic [31:0] CSR          = BASE + 32'd8;
    localparam int          BUSY_TIMEOUT = 1023;

    logic        sysclk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        mem_read, mem_write;
    logic [7:0]  uart_tx_data, uart_rx_data;
    logic        uart_tx_enable, uart_tx_status, uart_rx_status, uart_rx_enable, irq;

    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    int          c1, c2;
    bit          modelDrops = 1'b1;
    logic [7:0]  txExp[$];
    logic [31:0] rdExp[$];
    string       rdName[$];
    logic [7:0]  expByte;
    logic [31:0] expWord;
    string       expName;

    uart_mmio #(.BASE_ADDR(BASE), .TX_DEPTH(4), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .sysclk         (sysclk),
        .reset          (reset),
        .addr           (addr),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .wdata          (wdata),
        .rdata          (rdata),
        .uart_tx_data   (uart_tx_data),
        .uart_tx_enable (uart_tx_enable),
        .uart_tx_status (uart_tx_status),
        .uart_rx_data   (uart_rx_data),
        .uart_rx_status (uart_rx_status),
        .uart_rx_enable (uart_rx_enable),
        .irq            (irq)
    );

    initial forever #5 sysclk = ~sysclk;
    initial forever begin
        @(posedge sysclk);
        cycle++;
    end

    // UART model: goes busy 20 cycles after an enable, idle again 200 cycles later.
    initial begin
        uart_tx_status = 1'b1;
        forever begin
            @(posedge sysclk);
            if (uart_tx_enable && modelDrops) begin
                repeat (20) @(posedge sysclk);
                #1 uart_tx_status = 1'b0;
                repeat (200) @(posedge sysclk);
                #1 uart_tx_status = 1'b1;
            end
        end
    end

    // Monitor: compares every enable pulse and every bus read against the queues.
    initial forever begin
        @(negedge sysclk);
        if (uart_tx_enable === 1'b1) begin
            checks++;
            if (txExp.size() == 0) begin
                failures++;
                $display("[TB] FAIL tx_extra_pulse: got byte %h, required no pulse", uart_tx_data);
            end else begin
                expByte = txExp.pop_front();
                if (uart_tx_data !== expByte) begin
                    failures++;
                    $display("[TB] FAIL tx_byte: got %h, required %h", uart_tx_data, expByte);
                end
            end
        end
        if (mem_read === 1'b1) begin
            checks++;
            if (rdExp.size() == 0) begin
                failures++;
                $display("[TB] FAIL rd_unexpected: got %h, required no read", rdata);
            end else begin
                expWord = rdExp.pop_front();
                expName = rdName.pop_front();
                if (rdata !== expWord) begin
                    failures++;
                    $display("[TB] FAIL rd_%s: got %h, required %h", expName, rdata, expWord);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
        end
    endtask

    // One bus access; for reads, d is the value the monitor must see.
    task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] d, input string name);
        addr      = a;
        mem_write = wr;
        mem_read  = ~wr;
        wdata     = wr ? d : 32'h0;
        if (!wr) begin
            rdExp.push_back(d);
            rdName.push_back(name);
        end
        @(posedge sysclk);
        #1;
        mem_write = 1'b0;
        mem_read  = 1'b0;
    endtask

    task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(1'b1, a, d, "");
    endtask

    task automatic readReg(input logic [31:0] a, input logic [31:0] expected, input string name);
        applyStimulus(1'b0, a, expected, name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        addr = CSR;
        @(negedge sysclk);
        while (rdata[CSR_TX_IDLE] !== 1'b1 && n < bound) begin
            @(negedge sysclk);
            n++;
        end
        checkOutput("tx_idle_reached", 32'(rdata[CSR_TX_IDLE]), 32'h1);
        @(posedge sysclk);
        #1;
    endtask

    task automatic waitEnable(input int bound, output int when);
        int n = 0;
        @(negedge sysclk);
        while (uart_tx_enable !== 1'b1 && n < bound) begin
            @(negedge sysclk);
            n++;
        end
        checkOutput("tx_enable_seen", 32'(uart_tx_enable), 32'h1);
        when = cycle;
    endtask

    task automatic rxPulse(input logic [7:0] b, input int highCycles, input int lowCycles);
        uart_rx_data   = b;
        uart_rx_status = 1'b1;
        tick(highCycles);
        uart_rx_status = 1'b0;
        tick(lowCycles);
    endtask

    initial begin
        reset          = 1'b1;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        addr           = CSR;
        wdata          = '0;
        uart_rx_data   = '0;
        uart_rx_status = 1'b0;
        tick(3);
        @(negedge sysclk);
        checkOutput("reset_tx_enable", 32'(uart_tx_enable), 32'h0);
        checkOutput("reset_tx_data", 32'(uart_tx_data), 32'h0);
        checkOutput("reset_irq", 32'(irq), 32'h0);
        checkOutput("reset_csr", rdata, 32'h02);
        checkOutput("rx_enable_tied", 32'(uart_rx_enable), 32'h1);
        @(posedge sysclk);
        #1 reset = 1'b0;
        tick(2);

        $display("[TB] unmapped access");
        writeReg(BASE + 32'd12, 32'hFF);
        readReg(BASE + 32'd12, 32'h0, "unmapped");
        readReg(CSR, 32'h02, "csr_after_unmapped");

        $display("[TB] single byte transmit");
        txExp.push_back(8'h55);
        writeReg(TXD, 32'h55);
        @(negedge sysclk);
        checkOutput("tx_enable_before_pop", 32'(uart_tx_enable), 32'h0);
        @(negedge sysclk);
        checkOutput("tx_enable_latency", 32'(uart_tx_enable), 32'h1);
        @(posedge sysclk);
        #1;
        tick(10);
        readReg(CSR, 32'h00, "csr_busy");
        waitIdle(400);
        readReg(CSR, 32'h02, "csr_idle_after_tx");

        $display("[TB] FIFO overflow");
        txExp.push_back(8'hA0);
        writeReg(TXD, 32'hA0);
        tick(5);
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) txExp.push_back(8'(i));
            writeReg(TXD, 32'(i));
        end
        readReg(CSR, 32'h11, "csr_full_drop");
        writeReg(CSR, 32'h10);
        readReg(CSR, 32'h01, "csr_drop_cleared");
        waitIdle(4000);
        readReg(CSR, 32'h02, "csr_idle_after_burst");

        $display("[TB] RX capture");
        uart_rx_data   = 8'hA3;
        uart_rx_status = 1'b1;
        addr           = CSR;
        repeat (3) @(negedge sysclk);
        checkOutput("rx_valid_before_latency", 32'(rdata[CSR_RX_VALID]), 32'h0);
        @(negedge sysclk);
        checkOutput("rx_valid_at_latency", 32'(rdata[CSR_RX_VALID]), 32'h1);
        @(posedge sysclk);
        #1;
        readReg(CSR, 32'h06, "csr_rx_valid");
        readReg(RXD, 32'hA3, "rxd_a3");
        readReg(CSR, 32'h02, "csr_rx_cleared");
        tick(640);
        uart_rx_status = 1'b0;
        tick(5);
        readReg(CSR, 32'h02, "csr_single_capture");

        $display("[TB] RX overrun");
        rxPulse(8'h11, 10, 10);
        rxPulse(8'h22, 10, 10);
        readReg(CSR, 32'h0E, "csr_overrun");
        readReg(RXD, 32'h22, "rxd_22");
        writeReg(CSR, 32'h08);
        readReg(CSR, 32'h02, "csr_overrun_cleared");

        $display("[TB] RX event coinciding with read");
        rxPulse(8'h33, 10, 10);
        uart_rx_data   = 8'h44;
        uart_rx_status = 1'b1;
        tick(2);
        readReg(RXD, 32'h33, "rxd_old_byte");
        readReg(CSR, 32'h06, "csr_no_overrun");
        readReg(RXD, 32'h44, "rxd_new_byte");
        readReg(CSR, 32'h02, "csr_after_same_cycle");
        uart_rx_status = 1'b0;
        tick(5);

`ifdef UART_IRQ_EN
        $display("[TB] interrupt");
        writeReg(CSR, 32'h20);
        readReg(CSR, 32'h22, "csr_rx_irq_en");
        uart_rx_data   = 8'h5A;
        uart_rx_status = 1'b1;
        repeat (4) @(negedge sysclk);
        checkOutput("irq_with_rx_valid", 32'(irq), 32'h0);
        @(negedge sysclk);
        checkOutput("irq_after_rx_valid", 32'(irq), 32'h1);
        @(posedge sysclk);
        #1;
        readReg(RXD, 32'h5A, "rxd_5a");
        @(negedge sysclk);
        checkOutput("irq_at_read_edge", 32'(irq), 32'h1);
        @(negedge sysclk);
        checkOutput("irq_after_read", 32'(irq), 32'h0);
        @(posedge sysclk);
        #1 uart_rx_status = 1'b0;
        writeReg(CSR, 32'h40);
        @(negedge sysclk);
        checkOutput("irq_tx_before", 32'(irq), 32'h0);
        @(negedge sysclk);
        checkOutput("irq_tx_idle", 32'(irq), 32'h1);
        @(posedge sysclk);
        #1;
        readReg(CSR, 32'h42, "csr_tx_irq_en");
        writeReg(CSR, 32'h00);
        tick(2);
        checkOutput("irq_disabled", 32'(irq), 32'h0);
`else
        $display("[TB] interrupt disabled build");
        writeReg(CSR, 32'h60);
        readReg(CSR, 32'h02, "csr_irq_bits_absent");
        tick(3);
        checkOutput("irq_tied_low", 32'(irq), 32'h0);
`endif

        $display("[TB] busy timeout and reset mid-wait");
        modelDrops = 1'b0;
        txExp.push_back(8'h77);
        txExp.push_back(8'h77);
        writeReg(TXD, 32'h77);
        waitEnable(10, c1);
        waitEnable(BUSY_TIMEOUT + 100, c2);
        checkOutput("repulse_period", 32'(c2 - c1), 32'(BUSY_TIMEOUT + 2));
        @(posedge sysclk);
        #1;
        tick(100);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        addr  = CSR;
        @(negedge sysclk);
        checkOutput("reset_mid_enable", 32'(uart_tx_enable), 32'h0);
        checkOutput("reset_mid_tx_data", 32'(uart_tx_data), 32'h0);
        checkOutput("reset_mid_csr", rdata, 32'h02);
        @(posedge sysclk);
        #1;
        readReg(RXD, 32'h0, "rxd_after_reset");
        tick(5);

        checkOutput("tx_queue_drained", 32'(txExp.size()), 32'h0);
        checkOutput("rd_queue_drained", 32'(rdExp.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
